// File: rtl/hyperram_pkg.sv
// Shared types and command/address helpers for the HyperRAM bus master.
package hyperram_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        S_RSTW  = 3'd0,
        S_IDLE  = 3'd1,
        S_CA    = 3'd2,
        S_LAT   = 3'd3,
        S_WDATA = 3'd4,
        S_RDATA = 3'd5,
        S_END   = 3'd6
    } state_e;

    // Command/address word bit positions
    localparam int CA_RW_BIT    = 47;
    localparam int CA_AS_BIT    = 46;
    localparam int CA_BURST_BIT = 45;
    localparam int CA_ROW_HI    = 44;
    localparam int CA_ROW_LO    = 16;
    localparam int CA_COL_HI    = 2;
    localparam int CA_COL_LO    = 0;
    localparam int CA_BYTES     = 6;

    // Build the 48-bit command/address word for a single-word linear access
    function automatic logic [47:0] ca_build(
        input logic        we,
        input logic        reg_sp,
        input logic [21:0] addr
    );
        logic [47:0] ca;
        ca                         = 48'h0000_0000_0000;
        ca[CA_RW_BIT]              = ~we;
        ca[CA_AS_BIT]              = reg_sp;
        ca[CA_BURST_BIT]           = 1'b1;
        ca[CA_ROW_HI:CA_ROW_LO]    = {10'b0, addr[21:3]};
        ca[CA_COL_HI:CA_COL_LO]    = addr[2:0];
        return ca;
    endfunction

endpackage

// File: rtl/hyperram_rd_capture.sv
// Read-data capture: detects RWDS transitions on a registered copy of the pad
// and assembles two bytes into a word, with a timeout if RWDS stays quiet.
module hyperram_rd_capture
    import hyperram_pkg::*;
#(
    parameter int RD_TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [7:0]  i_dq,
    input  logic        i_rwds,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_word
);
    localparam int TMO_W = $clog2(RD_TIMEOUT) + 1;

    logic             r_rwds_q;
    logic             r_rwds_qq;
    logic [7:0]       r_dq_q;
    logic             r_hi_seen;
    logic             r_done;
    logic [TMO_W-1:0] r_tmo;
    logic [15:0]      r_word;
    logic             w_edge;
    logic             w_tmo_hit;

    // Register the pads so the edge detector and captured byte stay aligned
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rwds_q  <= 1'b0;
            r_rwds_qq <= 1'b0;
            r_dq_q    <= 8'h00;
        end else begin
            r_rwds_q  <= i_rwds;
            r_rwds_qq <= r_rwds_q;
            r_dq_q    <= i_dq;
        end
    end

    assign w_edge    = r_rwds_q ^ r_rwds_qq;
    assign w_tmo_hit = (r_tmo == TMO_W'(RD_TIMEOUT - 1));

    // Assemble high byte then low byte on each RWDS transition; count timeout
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hi_seen <= 1'b0;
            r_done    <= 1'b0;
            r_tmo     <= '0;
            r_word    <= 16'h0000;
        end else if (!i_en) begin
            r_hi_seen <= 1'b0;
            r_done    <= 1'b0;
            r_tmo     <= '0;
        end else begin
            if (!r_done) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
            if (w_edge && !r_done) begin
                if (!r_hi_seen) begin
                    r_word[15:8] <= r_dq_q;
                    r_hi_seen    <= 1'b1;
                end else begin
                    r_word[7:0]  <= r_dq_q;
                    r_done       <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_err  = i_en && !r_done && w_tmo_hit;
    assign o_word = r_word;

endmodule

// File: rtl/hyperram_ctrl.sv
// Single-word HyperBus master: turns a valid/ready word request into the
// CS/CK/CA/latency/data pin sequence and returns read data and status.
module hyperram_ctrl
    import hyperram_pkg::*;
#(
    parameter int RST_WAIT   = 300,
    parameter int LAT_CYC    = 20,
    parameter int RD_TIMEOUT = 64,
    parameter int CS_HIGH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic        i_req_reg,
    input  logic [21:0] i_req_addr,
    input  logic [15:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_rdata,
    output logic        o_rsp_err,
    input  logic [7:0]  dram_dq_in,
    output logic [7:0]  dram_dq_out,
    output logic        dram_dq_oe_l,
    input  logic        dram_rwds_in,
    output logic        dram_rwds_out,
    output logic        dram_rwds_oe_l,
    output logic        dram_ck,
    output logic        dram_rst_l,
    output logic        dram_cs_l
);
    localparam int CNT_W = $clog2(2 * RST_WAIT + LAT_CYC + CS_HIGH + 8) + 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;
    logic             w_active_nxt;
    logic             w_rsp_start;
    logic [47:0]      w_ca;
    logic             r_we;
    logic             r_reg;
    logic [15:0]      r_wdata;
    logic [47:0]      r_ca_sh;
    logic             w_cap_en;
    logic             w_cap_done;
    logic             w_cap_err;
    logic [15:0]      w_cap_word;

    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [15:0]      r_rsp_rdata;
    logic             r_rsp_err;
    logic [7:0]       r_dq_out;
    logic             r_dq_oe_l;
    logic             r_rwds_out;
    logic             r_rwds_oe_l;
    logic             r_ck;
    logic             r_rst_l;
    logic             r_cs_l;

    assign w_accept     = (r_state == S_IDLE) && i_req_valid;
    assign w_ca         = ca_build(i_req_we, i_req_reg, i_req_addr);
    assign w_active_nxt = (w_state_nxt == S_CA) || (w_state_nxt == S_LAT) ||
                          (w_state_nxt == S_WDATA) || (w_state_nxt == S_RDATA);
    assign w_rsp_start  = (w_state_nxt == S_END) && (r_state != S_END);
    assign w_cap_en     = (r_state == S_RDATA);

    hyperram_rd_capture #(
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_rd_capture (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_cap_en),
        .i_dq   (dram_dq_in),
        .i_rwds (dram_rwds_in),
        .o_done (w_cap_done),
        .o_err  (w_cap_err),
        .o_word (w_cap_word)
    );

    // Next-state and per-state cycle counter
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RSTW:  w_state_nxt = (r_cnt == CNT_W'(2 * RST_WAIT - 1)) ? S_IDLE : S_RSTW;
            S_IDLE:  w_state_nxt = i_req_valid ? S_CA : S_IDLE;
            S_CA: begin
                if (r_cnt == CNT_W'(CA_BYTES - 1)) begin
                    w_state_nxt = (r_we && r_reg) ? S_WDATA : S_LAT;
                end else begin
                    w_state_nxt = S_CA;
                end
            end
            S_LAT: begin
                if (r_cnt == CNT_W'(LAT_CYC - 1)) begin
                    w_state_nxt = r_we ? S_WDATA : S_RDATA;
                end else begin
                    w_state_nxt = S_LAT;
                end
            end
            S_WDATA: w_state_nxt = (r_cnt == CNT_W'(1)) ? S_END : S_WDATA;
            S_RDATA: w_state_nxt = (w_cap_done || w_cap_err) ? S_END : S_RDATA;
            S_END:   w_state_nxt = (r_cnt == CNT_W'(CS_HIGH - 1)) ? S_IDLE : S_END;
            default: w_state_nxt = S_RSTW;
        endcase

        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // State and counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_RSTW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Latch the accepted request for the rest of the transaction
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we    <= 1'b0;
            r_reg   <= 1'b0;
            r_wdata <= 16'h0000;
        end else if (w_accept) begin
            r_we    <= i_req_we;
            r_reg   <= i_req_reg;
            r_wdata <= i_req_wdata;
        end
    end

    // Pad and response registers, decoded from the upcoming state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cs_l      <= 1'b1;
            r_ck        <= 1'b0;
            r_rst_l     <= 1'b0;
            r_dq_oe_l   <= 1'b1;
            r_rwds_oe_l <= 1'b1;
            r_dq_out    <= 8'h00;
            r_rwds_out  <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 16'h0000;
            r_rsp_err   <= 1'b0;
            r_ca_sh     <= 48'h0000_0000_0000;
        end else begin
            r_cs_l      <= ~w_active_nxt;
            r_ck        <= w_active_nxt ? ~r_ck : 1'b0;
            r_rst_l     <= (r_state != S_RSTW) || (r_cnt >= CNT_W'(RST_WAIT - 1));
            r_dq_oe_l   <= ~((w_state_nxt == S_CA) || (w_state_nxt == S_WDATA));
            r_rwds_oe_l <= ~((w_state_nxt == S_WDATA) && !r_reg);
            r_rwds_out  <= 1'b0;
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= w_rsp_start;
            r_rsp_err   <= w_rsp_start && (r_state == S_RDATA) && !w_cap_done;

            // CA bytes go out MSB-first; byte 0 leaves on the accept edge
            if (w_accept) begin
                r_dq_out <= w_ca[47:40];
                r_ca_sh  <= {w_ca[39:0], 8'h00};
            end else if (w_state_nxt == S_CA) begin
                r_dq_out <= r_ca_sh[47:40];
                r_ca_sh  <= {r_ca_sh[39:0], 8'h00};
            end else if (w_state_nxt == S_WDATA) begin
                r_dq_out <= (w_cnt_nxt == '0) ? r_wdata[15:8] : r_wdata[7:0];
            end else begin
                r_dq_out <= 8'h00;
            end

            // Read data only changes on a successful read completion
            if (w_rsp_start && (r_state == S_RDATA) && w_cap_done) begin
                r_rsp_rdata <= w_cap_word;
            end
        end
    end

    assign o_req_ready    = r_req_ready;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_rdata    = r_rsp_rdata;
    assign o_rsp_err      = r_rsp_err;
    assign dram_dq_out    = r_dq_out;
    assign dram_dq_oe_l   = r_dq_oe_l;
    assign dram_rwds_out  = r_rwds_out;
    assign dram_rwds_oe_l = r_rwds_oe_l;
    assign dram_ck        = r_ck;
    assign dram_rst_l     = r_rst_l;
    assign dram_cs_l      = r_cs_l;

endmodule

// File: tb/tb_hyperram_ctrl.sv
// Self-checking bench for hyperram_ctrl with a small behavioural HyperRAM
// device and a response scoreboard.
module tb_hyperram_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic        i_req_reg;
    logic [21:0] i_req_addr;
    logic [15:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [15:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [7:0]  dram_dq_in;
    logic [7:0]  dram_dq_out;
    logic        dram_dq_oe_l;
    logic        dram_rwds_in;
    logic        dram_rwds_out;
    logic        dram_rwds_oe_l;
    logic        dram_ck;
    logic        dram_rst_l;
    logic        dram_cs_l;

    always #5 i_clk = ~i_clk;

    hyperram_ctrl dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_reg      (i_req_reg),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .dram_dq_in     (dram_dq_in),
        .dram_dq_out    (dram_dq_out),
        .dram_dq_oe_l   (dram_dq_oe_l),
        .dram_rwds_in   (dram_rwds_in),
        .dram_rwds_out  (dram_rwds_out),
        .dram_rwds_oe_l (dram_rwds_oe_l),
        .dram_ck        (dram_ck),
        .dram_rst_l     (dram_rst_l),
        .dram_cs_l      (dram_cs_l)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // {cs_l, ck, rst_l, dq_oe_l, rwds_oe_l, rwds_out, ready, rsp_valid, rsp_err, dq_out}
    localparam logic [31:0] RST_PADS = 32'h0001_3000;

    function automatic logic [31:0] pad_vec();
        return {15'b0, dram_cs_l, dram_ck, dram_rst_l, dram_dq_oe_l, dram_rwds_oe_l,
                dram_rwds_out, o_req_ready, o_rsp_valid, o_rsp_err, dram_dq_out};
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        err;
        logic [15:0] rdata;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   rsp_cnt = 0;

    initial begin
        forever begin
            @(negedge i_clk);
            if (o_rsp_valid === 1'b1) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_err", {31'b0, o_rsp_err}, {31'b0, mon_e.err});
                    check("rsp_rdata", {16'b0, o_rsp_rdata}, {16'b0, mon_e.rdata});
                end
            end
        end
    end

    // ---------------- device model ----------------
    logic [15:0] mem [int];
    logic [7:0]  rec_dq      [0:127];
    logic        rec_dq_oe   [0:127];
    logic        rec_rwds_oe [0:127];
    logic        rec_rwds_o  [0:127];
    logic        rec_ck      [0:127];
    int          k = 0;
    int          rec_len = 0;
    int          hi_run = 0;
    int          last_gap = 0;
    logic        prev_cs = 1'b1;
    logic        hold_rwds = 1'b0;
    logic [47:0] dev_ca = 48'h0;
    logic [15:0] dev_word = 16'h0;
    int          dev_addr;

    initial begin
        dram_dq_in   = 8'h00;
        dram_rwds_in = 1'b0;
        forever begin
            @(negedge i_clk);
            if (dram_cs_l === 1'b0) begin
                if (prev_cs === 1'b1) begin
                    last_gap = hi_run;
                    k = 0;
                end
                if (k < 128) begin
                    rec_dq[k]      = dram_dq_out;
                    rec_dq_oe[k]   = dram_dq_oe_l;
                    rec_rwds_oe[k] = dram_rwds_oe_l;
                    rec_rwds_o[k]  = dram_rwds_out;
                    rec_ck[k]      = dram_ck;
                end
                if (k < 6) begin
                    dev_ca = {dev_ca[39:0], dram_dq_out};
                end
                dev_addr = int'({dev_ca[34:16], dev_ca[2:0]});
                if (k == 5 && dev_ca[47]) begin
                    dev_word = mem.exists(dev_addr) ? mem[dev_addr] : 16'h0000;
                end
                if (dev_ca[47] && !hold_rwds && k == 28) begin
                    dram_dq_in   = dev_word[15:8];
                    dram_rwds_in = 1'b1;
                end else if (dev_ca[47] && !hold_rwds && k == 30) begin
                    dram_dq_in   = dev_word[7:0];
                    dram_rwds_in = 1'b0;
                end
                k++;
                rec_len = k;
                hi_run = 0;
            end else begin
                if (prev_cs === 1'b0 && !dev_ca[47] && !dev_ca[46] && rec_len >= 28) begin
                    mem[dev_addr] = {rec_dq[26], rec_dq[27]};
                end
                dram_dq_in   = 8'h00;
                dram_rwds_in = 1'b0;
                hi_run++;
            end
            prev_cs = dram_cs_l;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic we, input logic rg, input logic [21:0] addr,
                        input logic [15:0] wd, input logic exp_rsp, input logic exp_err,
                        input logic [15:0] exp_rd, input logic keep);
        int   b;
        rsp_t e;
        b = 0;
        @(negedge i_clk);
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_reg   = rg;
        i_req_addr  = addr;
        i_req_wdata = wd;
        while (o_req_ready !== 1'b1 && b < 400) begin
            @(negedge i_clk);
            b++;
        end
        check("req_accept", {31'b0, (b < 400)}, 32'd1);
        if (exp_rsp) begin
            e.err   = exp_err;
            e.rdata = exp_rd;
            exp_q.push_back(e);
        end
        @(negedge i_clk);
        i_req_valid = keep;
    endtask

    task automatic wait_rsp(input string tag);
        int b;
        b = 0;
        while (o_rsp_valid !== 1'b1 && b < 400) begin
            @(negedge i_clk);
            b++;
        end
        check(tag, {31'b0, (b < 400)}, 32'd1);
    endtask

    function automatic int ck_errs();
        int e;
        e = 0;
        for (int i = 0; i < rec_len && i < 128; i++) begin
            if (rec_ck[i] !== ((i % 2) == 0)) e++;
        end
        return e;
    endfunction

    // ---------------- main sequence ----------------
    logic [7:0] exp_ca [0:5];
    int         cnt;
    int         first_ready;
    int         saved_rsp;

    initial begin
        i_rst       = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_reg   = 1'b0;
        i_req_addr  = 22'h0;
        i_req_wdata = 16'h0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_pads", pad_vec(), RST_PADS);
        check("reset_rdata", {16'b0, o_rsp_rdata}, 32'd0);

        // 1. reset sequencing
        i_rst = 1'b0;
        first_ready = 0;
        for (int n = 1; n <= 600; n++) begin
            @(negedge i_clk);
            if (n == 299) check("rst_l_low_299", {31'b0, dram_rst_l}, 32'd0);
            if (n == 300) check("rst_l_high_300", {31'b0, dram_rst_l}, 32'd1);
            if (o_req_ready === 1'b1 && first_ready == 0) first_ready = n;
        end
        check("ready_first_cycle", first_ready, 32'd600);

        // 2. memory write 0xBEEF to 0x000123
        send(1'b1, 1'b0, 22'h000123, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0);
        wait_rsp("wr_rsp_seen");
        exp_ca[0] = 8'h20; exp_ca[1] = 8'h00; exp_ca[2] = 8'h00;
        exp_ca[3] = 8'h24; exp_ca[4] = 8'h00; exp_ca[5] = 8'h03;
        for (int i = 0; i < 6; i++) check($sformatf("wr_ca%0d", i), {24'b0, rec_dq[i]}, {24'b0, exp_ca[i]});
        cnt = 0;
        for (int i = 6; i < 26; i++) if (rec_dq_oe[i] !== 1'b1 || rec_rwds_oe[i] !== 1'b1) cnt++;
        check("wr_lat_released", cnt, 32'd0);
        check("wr_len", rec_len, 32'd28);
        check("wr_data", {16'b0, rec_dq[26], rec_dq[27]}, 32'h0000_BEEF);
        check("wr_oe", {28'b0, rec_dq_oe[26], rec_dq_oe[27], rec_rwds_oe[26], rec_rwds_oe[27]}, 32'd0);
        check("wr_rwds_mask", {30'b0, rec_rwds_o[26], rec_rwds_o[27]}, 32'd0);
        check("wr_ck", ck_errs(), 32'd0);
        @(negedge i_clk);
        check("end_pads_idle", {30'b0, dram_cs_l, dram_ck}, 32'd2);

        // 3. read back
        send(1'b0, 1'b0, 22'h000123, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b0);
        wait_rsp("rd_rsp_seen");
        check("rd_ca0", {24'b0, rec_dq[0]}, 32'h0000_00A0);

        // 4. register write CR0, zero latency
        send(1'b1, 1'b1, 22'h000800, 16'h8F1F, 1'b1, 1'b0, 16'hBEEF, 1'b0);
        wait_rsp("rg_rsp_seen");
        exp_ca[0] = 8'h60; exp_ca[1] = 8'h00; exp_ca[2] = 8'h01;
        exp_ca[3] = 8'h00; exp_ca[4] = 8'h00; exp_ca[5] = 8'h00;
        for (int i = 0; i < 6; i++) check($sformatf("rg_ca%0d", i), {24'b0, rec_dq[i]}, {24'b0, exp_ca[i]});
        check("rg_len", rec_len, 32'd8);
        check("rg_data", {16'b0, rec_dq[6], rec_dq[7]}, 32'h0000_8F1F);
        cnt = 0;
        for (int i = 0; i < rec_len; i++) if (rec_rwds_oe[i] !== 1'b1) cnt++;
        check("rg_rwds_undriven", cnt, 32'd0);

        // 5. read timeout with RWDS held
        hold_rwds = 1'b1;
        send(1'b0, 1'b0, 22'h000123, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 1'b0);
        wait_rsp("tmo_rsp_seen");
        check("tmo_len", rec_len, 32'd90);
        check("tmo_ck", ck_errs(), 32'd0);
        hold_rwds = 1'b0;

        // 6. back-to-back with valid held
        send(1'b1, 1'b0, 22'h000040, 16'h1234, 1'b1, 1'b0, 16'hBEEF, 1'b1);
        send(1'b0, 1'b0, 22'h000040, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b0);
        wait_rsp("b2b_rsp_seen");
        check("b2b_cs_gap", {31'b0, (last_gap >= 4)}, 32'd1);

        // reset in the middle of LAT
        send(1'b0, 1'b0, 22'h000123, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (10) @(negedge i_clk);
        saved_rsp = rsp_cnt;
        i_rst = 1'b1;
        @(negedge i_clk);
        check("midrst_pads", pad_vec(), RST_PADS);
        i_rst = 1'b0;
        repeat (700) @(negedge i_clk);
        check("midrst_no_rsp", rsp_cnt, saved_rsp);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
